// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (req0)
// and load (req1) writeback, with a registered write stage and r0-drop counter.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         req0_valid,
  input  logic [ADDR_WIDTH-1:0]        req0_reg,
  input  logic [DATA_WIDTH-1:0]        req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [ADDR_WIDTH-1:0]        req1_reg,
  input  logic [DATA_WIDTH-1:0]        req1_data,
  output logic                         req1_ready,
  output logic                         write_en,
  output logic [ADDR_WIDTH-1:0]        write_reg,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [(1<<ADDR_WIDTH)-1:0]   pending_mask,
  output logic [CNT_WIDTH-1:0]         zero_drops
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  last_grant_q, last_grant_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [CNT_WIDTH-1:0]  zero_drops_q, zero_drops_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  // Handshake: a transfer happens when reqX_valid && reqX_ready in the same
  // cycle; ready is a function of valids, stall, rst and last_grant only, and
  // requesters keep valid/reg/data stable until they see ready.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && !stall) begin
      req0_ready = req0_valid && (!req1_valid || last_grant_q);
      req1_ready = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  always_comb begin
    xfer     = req0_ready || req1_ready;
    sel_reg  = req1_ready ? req1_reg  : req0_reg;
    sel_data = req1_ready ? req1_data : req0_data;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    zero_drops_d = zero_drops_q;
    if (rst) begin
      last_grant_d = 1'b1;
      write_reg_d  = '0;
      write_data_d = '0;
      zero_drops_d = '0;
    end else if (xfer) begin
      last_grant_d = req1_ready;
      if (sel_reg != '0) begin
        write_en_d   = 1'b1;
        write_reg_d  = sel_reg;
        write_data_d = sel_data;
      end else if (zero_drops_q != CNT_MAX) begin
        zero_drops_d = zero_drops_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    last_grant_q <= last_grant_d;
    write_en_q   <= write_en_d;
    write_reg_q  <= write_reg_d;
    write_data_q <= write_data_d;
    zero_drops_q <= zero_drops_d;
  end

  // Hazard view: one-hot of the register being written this cycle.
  always_comb begin
    pending_mask = '0;
    if (write_en_q) pending_mask[write_reg_q] = 1'b1;
  end

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign zero_drops = zero_drops_q;

endmodule
